// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the IF/MEM memory-port arbiter.
package mem_arbiter_pkg;

    // Arbiter FSM state encodings.
    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_BUSY_IF  = 3'd1,
        ARB_BUSY_MEM = 3'd2,
        ARB_RESP_IF  = 3'd3,
        ARB_RESP_MEM = 3'd4
    } arb_state_e;

    // Watchdog counter width; a disabled watchdog (0) still gets one bit.
    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Clear/enable watchdog counter bounding one bus transaction.
module mem_arb_timer
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CntW = timer_width(TIMEOUT);

    logic [CntW-1:0] count;

    // Count enabled cycles since the last clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CntW'(1);
        end
    end

    // Fires in the cycle whose increment would bring the count to TIMEOUT.
    assign expired = en && (TIMEOUT != 0) && ((32'(count) + 32'd1) == TIMEOUT);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto a single req/ack memory bus.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_ren,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_data,
    output logic                  if_stall,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_din,
    output logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  mem_stall,
    output logic                  bus_cs,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_dout,
    input  logic [DATA_WIDTH-1:0] bus_din,
    input  logic                  bus_ack,
    output logic                  bus_timeout
);

    arb_state_e state, state_next;

    logic                  bus_cs_next;
    logic                  bus_we_next;
    logic [ADDR_WIDTH-1:0] bus_addr_next;
    logic [DATA_WIDTH-1:0] bus_dout_next;
    logic [DATA_WIDTH-1:0] if_data_next;
    logic [DATA_WIDTH-1:0] mem_dout_next;
    logic                  bus_timeout_next;
    logic                  tmr_clr;
    logic                  tmr_en;
    logic                  tmr_expired;
    logic                  mem_req;

    assign mem_req = mem_ren | mem_wen;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Next-state, bus register and data register update.
    always_comb begin
        state_next       = state;
        bus_cs_next      = bus_cs;
        bus_we_next      = bus_we;
        bus_addr_next    = bus_addr;
        bus_dout_next    = bus_dout;
        if_data_next     = if_data;
        mem_dout_next    = mem_dout;
        bus_timeout_next = 1'b0;
        tmr_clr          = 1'b0;
        tmr_en           = 1'b0;

        case (state)
            ARB_IDLE: begin
                // MEM wins: it belongs to the older instruction.
                if (mem_req) begin
                    state_next    = ARB_BUSY_MEM;
                    bus_cs_next   = 1'b1;
                    bus_we_next   = mem_wen;
                    bus_addr_next = mem_addr;
                    if (mem_wen) begin
                        bus_dout_next = mem_din;
                    end
                    tmr_clr = 1'b1;
                end else if (if_ren) begin
                    state_next    = ARB_BUSY_IF;
                    bus_cs_next   = 1'b1;
                    bus_we_next   = 1'b0;
                    bus_addr_next = if_addr;
                    tmr_clr       = 1'b1;
                end
            end

            ARB_BUSY_IF: begin
                tmr_en = !bus_ack;
                if (bus_ack) begin
                    bus_cs_next  = 1'b0;
                    if_data_next = bus_din;
                    state_next   = ARB_RESP_IF;
                end else if (tmr_expired) begin
                    bus_cs_next      = 1'b0;
                    if_data_next     = '0;
                    bus_timeout_next = 1'b1;
                    state_next       = ARB_RESP_IF;
                end
            end

            ARB_BUSY_MEM: begin
                tmr_en = !bus_ack;
                // A store never touches mem_dout, even on timeout.
                if (bus_ack) begin
                    bus_cs_next = 1'b0;
                    if (!bus_we) begin
                        mem_dout_next = bus_din;
                    end
                    state_next = ARB_RESP_MEM;
                end else if (tmr_expired) begin
                    bus_cs_next = 1'b0;
                    if (!bus_we) begin
                        mem_dout_next = '0;
                    end
                    bus_timeout_next = 1'b1;
                    state_next       = ARB_RESP_MEM;
                end
            end

            ARB_RESP_IF, ARB_RESP_MEM: begin
                state_next = ARB_IDLE;
            end

            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus and returned-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_cs      <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_dout    <= '0;
            if_data     <= '0;
            mem_dout    <= '0;
            bus_timeout <= 1'b0;
        end else begin
            bus_cs      <= bus_cs_next;
            bus_we      <= bus_we_next;
            bus_addr    <= bus_addr_next;
            bus_dout    <= bus_dout_next;
            if_data     <= if_data_next;
            mem_dout    <= mem_dout_next;
            bus_timeout <= bus_timeout_next;
        end
    end

    // A requester is released only in its own RESP cycle; a dropped request raises no stall.
    assign if_stall  = if_ren & (state != ARB_RESP_IF);
    assign mem_stall = mem_req & (state != ARB_RESP_MEM);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (long and short watchdog) share one stimulus stream.
module tb_mem_arbiter;

    localparam int TO_M = 16;
    localparam int TO_T = 4;

    logic        clk;
    logic        rst;
    logic        if_ren, mem_ren, mem_wen;
    logic [31:0] if_addr, mem_addr, mem_din;
    logic [31:0] bus_din;
    logic        bus_ack;
    logic        resp_ack, stray_ack;

    logic [31:0] if_data_m, mem_dout_m, bus_addr_m, bus_dout_m;
    logic        if_stall_m, mem_stall_m, bus_cs_m, bus_we_m, bus_timeout_m;
    logic [31:0] if_data_t, mem_dout_t, bus_addr_t, bus_dout_t;
    logic        if_stall_t, mem_stall_t, bus_cs_t, bus_we_t, bus_timeout_t;

    int          n_checks = 0;
    int          n_errors = 0;

    // Bus responder controls
    bit          resp_en;
    int          resp_wait;
    logic [31:0] resp_data;
    int          cs_cnt;

    assign bus_ack = resp_ack | stray_ack;
    assign bus_din = resp_data;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO_M)) dut_m (
        .clk(clk), .rst(rst), .if_ren(if_ren), .if_addr(if_addr), .if_data(if_data_m),
        .if_stall(if_stall_m), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout_m), .mem_stall(mem_stall_m), .bus_cs(bus_cs_m),
        .bus_we(bus_we_m), .bus_addr(bus_addr_m), .bus_dout(bus_dout_m), .bus_din(bus_din),
        .bus_ack(bus_ack), .bus_timeout(bus_timeout_m)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO_T)) dut_t (
        .clk(clk), .rst(rst), .if_ren(if_ren), .if_addr(if_addr), .if_data(if_data_t),
        .if_stall(if_stall_t), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout_t), .mem_stall(mem_stall_t), .bus_cs(bus_cs_t),
        .bus_we(bus_we_t), .bus_addr(bus_addr_t), .bus_dout(bus_dout_t), .bus_din(bus_din),
        .bus_ack(bus_ack), .bus_timeout(bus_timeout_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish within its time budget");
        $fatal(1, "time budget exhausted");
    end

    // Responder follows the long-watchdog instance: ack after resp_wait BUSY cycles.
    always @(negedge clk) begin
        if (bus_cs_m) begin
            resp_ack = resp_en && (cs_cnt == resp_wait);
            cs_cnt++;
        end else begin
            resp_ack = 1'b0;
            cs_cnt   = 0;
        end
    end

    // ---------------- transaction-level model ----------------
    // phase: 0 waiting for a request, 1 on the bus, 2 answer cycle
    int          ph [2];
    int          who [2];     // 0 fetch, 1 data access
    int          waited [2];  // BUSY cycles elapsed without ack
    logic        cs_e [2], we_e [2], to_e [2];
    logic [31:0] addr_e [2], dout_e [2], ifd_e [2], memd_e [2];

    function automatic int limit(input int k);
        return (k == 0) ? TO_M : TO_T;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                ph[k] = 0; who[k] = 0; waited[k] = 0;
                cs_e[k] = 1'b0; we_e[k] = 1'b0; to_e[k] = 1'b0;
                addr_e[k] = '0; dout_e[k] = '0; ifd_e[k] = '0; memd_e[k] = '0;
            end else begin
                to_e[k] = 1'b0;
                if (ph[k] == 0) begin
                    if (mem_ren || mem_wen) begin
                        ph[k] = 1; who[k] = 1; waited[k] = 0;
                        cs_e[k] = 1'b1; we_e[k] = mem_wen; addr_e[k] = mem_addr;
                        if (mem_wen) dout_e[k] = mem_din;
                    end else if (if_ren) begin
                        ph[k] = 1; who[k] = 0; waited[k] = 0;
                        cs_e[k] = 1'b1; we_e[k] = 1'b0; addr_e[k] = if_addr;
                    end
                end else if (ph[k] == 1) begin
                    if (bus_ack) begin
                        cs_e[k] = 1'b0; ph[k] = 2;
                        if (who[k] == 0) ifd_e[k] = bus_din;
                        else if (!we_e[k]) memd_e[k] = bus_din;
                    end else begin
                        waited[k]++;
                        if (limit(k) != 0 && waited[k] == limit(k)) begin
                            cs_e[k] = 1'b0; ph[k] = 2; to_e[k] = 1'b1;
                            if (who[k] == 0) ifd_e[k] = '0;
                            else if (!we_e[k]) memd_e[k] = '0;
                        end
                    end
                end else begin
                    ph[k] = 0;
                end
            end
        end
    end

    function automatic logic [132:0] pk(input logic is, input logic ms, input logic cs,
                                        input logic we, input logic to, input logic [31:0] a,
                                        input logic [31:0] d, input logic [31:0] id,
                                        input logic [31:0] md);
        return {is, ms, cs, we, to, a, d, id, md};
    endfunction

    task automatic check_vec(input string name, input logic [132:0] act, input logic [132:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    logic [132:0] exp_v, act_v;

    // Every cycle: both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_v = pk(if_ren && !(ph[k] == 2 && who[k] == 0),
                       (mem_ren || mem_wen) && !(ph[k] == 2 && who[k] == 1),
                       cs_e[k], we_e[k], to_e[k], addr_e[k], dout_e[k], ifd_e[k], memd_e[k]);
            if (k == 0) begin
                act_v = pk(if_stall_m, mem_stall_m, bus_cs_m, bus_we_m, bus_timeout_m,
                           bus_addr_m, bus_dout_m, if_data_m, mem_dout_m);
                check_vec("cycle_m", act_v, exp_v);
            end else begin
                act_v = pk(if_stall_t, mem_stall_t, bus_cs_t, bus_we_t, bus_timeout_t,
                           bus_addr_t, bus_dout_t, if_data_t, mem_dout_t);
                check_vec("cycle_t", act_v, exp_v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // One request on the long-watchdog instance; checks stall length, address and data.
    task automatic run_single(input bit is_mem, input logic [31:0] addr, input int wait_n,
                              input logic [31:0] data, input string name, input int exp_n);
        int n;
        bit done;
        bit addr_seen;
        logic st;
        resp_en = 1'b1; resp_wait = wait_n; resp_data = data;
        tick();
        if (is_mem) begin mem_ren = 1'b1; mem_addr = addr; end
        else begin if_ren = 1'b1; if_addr = addr; end
        n = 0; done = 1'b0; addr_seen = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (bus_cs_m && !addr_seen) begin
                addr_seen = 1'b1;
                check32({name, "_addr"}, bus_addr_m, addr);
            end
            st = is_mem ? mem_stall_m : if_stall_m;
            if (st) begin
                n++;
            end else begin
                done = 1'b1;
                check32({name, "_stall_cycles"}, n, exp_n);
                check32({name, "_data"}, is_mem ? mem_dout_m : if_data_m, data);
            end
        end
        check32({name, "_released"}, {31'b0, done}, 32'd1);
        check32({name, "_bus_seen"}, {31'b0, addr_seen}, 32'd1);
        tick();
        if (is_mem) mem_ren = 1'b0; else if_ren = 1'b0;
    endtask

    initial begin
        int n_if, n_mem, rises, n_cs, n_to_t, n_to_m, n_st;
        bit prev_cs, done;

        rst = 1'b1; if_ren = 0; mem_ren = 0; mem_wen = 0;
        if_addr = '0; mem_addr = '0; mem_din = '0;
        resp_en = 1'b1; resp_wait = 0; resp_data = '0; stray_ack = 1'b0;
        resp_ack = 1'b0; cs_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_vec("reset_state", pk(if_stall_m, mem_stall_m, bus_cs_m, bus_we_m, bus_timeout_m,
                  bus_addr_m, bus_dout_m, if_data_m, mem_dout_m), '0);

        // Zero-wait fetch
        run_single(1'b0, 32'h0000_0100, 0, 32'h2402_0005, "fetch", 2);
        idle(3);

        // Simultaneous store and fetch: store first, fetch after one IDLE
        resp_en = 1'b1; resp_wait = 0; resp_data = 32'h8C08_0004;
        tick();
        if_ren = 1'b1; if_addr = 32'h0000_0300;
        mem_wen = 1'b1; mem_addr = 32'h0000_0040; mem_din = 32'hDEAD_BEEF;
        n_if = 0; n_mem = 0; rises = 0; prev_cs = 1'b0; done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (bus_cs_m && !prev_cs) begin
                rises++;
                if (rises == 1) begin
                    check32("both_first_we", {31'b0, bus_we_m}, 32'd1);
                    check32("both_first_addr", bus_addr_m, 32'h0000_0040);
                    check32("both_first_dout", bus_dout_m, 32'hDEAD_BEEF);
                end else if (rises == 2) begin
                    check32("both_second_addr", bus_addr_m, 32'h0000_0300);
                end
            end
            prev_cs = bus_cs_m;
            if (mem_wen && mem_stall_m) n_mem++;
            if (if_stall_m) begin
                n_if++;
            end else begin
                done = 1'b1;
                check32("both_if_stall_cycles", n_if, 32'd5);
                check32("both_mem_stall_cycles", n_mem, 32'd2);
                check32("both_if_data", if_data_m, 32'h8C08_0004);
            end
            if (mem_wen && !mem_stall_m) begin
                tick();
                mem_wen = 1'b0;
            end
        end
        check32("both_released", {31'b0, done}, 32'd1);
        check32("both_bus_starts", rises, 32'd2);
        tick();
        if_ren = 1'b0;
        idle(3);

        // Load with five wait cycles (short-watchdog instance times out here)
        run_single(1'b1, 32'h0000_0088, 5, 32'h0000_1234, "load_wait5", 7);
        idle(14);

        // No ack at all: short watchdog fires after 4 BUSY cycles, long one after 16
        resp_en = 1'b0; resp_data = 32'h0BAD_0BAD;
        tick();
        if_ren = 1'b1; if_addr = 32'h0000_0400;
        n_cs = 0; n_to_t = 0; n_to_m = 0; n_st = 0; done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus_cs_t) n_cs++;
            if (bus_timeout_t) n_to_t++;
            if (bus_timeout_m) n_to_m++;
            if (!done) begin
                if (if_stall_t) begin
                    n_st++;
                end else begin
                    done = 1'b1;
                    check32("timeout_stall_cycles", n_st, 32'd5);
                    check32("timeout_pulse_in_resp", {31'b0, bus_timeout_t}, 32'd1);
                    check32("timeout_if_data", if_data_t, 32'd0);
                    tick();
                    if_ren = 1'b0;
                end
            end
        end
        check32("timeout_released", {31'b0, done}, 32'd1);
        check32("timeout_cs_cycles", n_cs, 32'd4);
        check32("timeout_pulses_t", n_to_t, 32'd1);
        check32("timeout_pulses_m", n_to_m, 32'd1);
        resp_en = 1'b1;
        idle(3);

        // Fetch dropped mid-transaction: bus still completes, no stall afterwards
        resp_wait = 2; resp_data = 32'h0000_FFFF;
        tick();
        if_ren = 1'b1; if_addr = 32'h0000_0500;
        @(negedge clk);
        tick();
        if_ren = 1'b0;
        n_st = 0; n_cs = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (if_stall_m) n_st++;
            if (bus_cs_m) n_cs++;
        end
        check32("drop_no_stall", n_st, 32'd0);
        check32("drop_bus_completes", n_cs, 32'd3);
        run_single(1'b0, 32'h0000_0600, 0, 32'h0000_ABCD, "refetch", 2);
        idle(3);

        // Asynchronous reset in the middle of a load, then a stray ack
        resp_en = 1'b1; resp_wait = 3; resp_data = 32'h5555_5555;
        tick();
        mem_ren = 1'b1; mem_addr = 32'h0000_0080;
        tick();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check32("arst_bus_cs", {31'b0, bus_cs_m}, 32'd0);
        check32("arst_bus_cs_t", {31'b0, bus_cs_t}, 32'd0);
        check32("arst_bus_addr", bus_addr_m, 32'd0);
        check32("arst_bus_dout", bus_dout_m, 32'd0);
        check32("arst_mem_dout", mem_dout_m, 32'd0);
        check32("arst_if_data", if_data_m, 32'd0);
        check32("arst_mem_stall_eq", {31'b0, mem_stall_m}, 32'd1);
        mem_ren = 1'b0;
        tick();
        rst = 1'b0;
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        n_cs = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus_cs_m || bus_cs_t) n_cs++;
        end
        check32("stray_ack_ignored", n_cs, 32'd0);
        check32("stray_ack_mem_dout", mem_dout_m, 32'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
